// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage with variable-latency imem handshake
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   StallF                  fetch stall from hazard unit (includes ImemBusyF)
//   PCSrcD, PCBranchD       taken branch from decode and its target
//   JumpD, PCJumpD          jump from decode and its target
//   imem_req, imem_addr     fetch request (held until acked) and address (= PCF)
//   imem_ack, imem_rdata    read-data-valid strobe and instruction word
//   PCF, PCPlus4F, instr    current PC, PC+4 and instruction toward IF/ID
//   ImemBusyF               fetch outstanding; F and D must stall
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] instr,
    output logic        ImemBusyF
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] instr_buf;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic        pc_advance;
    logic        capture;

    assign PCF       = pc_q;
    assign imem_addr = pc_q;
    assign PCPlus4F  = pc_q + 32'd4;

    // Jump outranks branch; the low two bits are cleared so a misaligned
    // target can never reach the instruction memory.
    always_comb begin
        target = PCPlus4F;
        if (JumpD) begin
            target = PCJumpD;
        end else if (PCSrcD) begin
            target = PCBranchD;
        end
        next_pc = target & 32'hFFFF_FFFC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            pc_q      <= RESET_PC;
            instr_buf <= NOP_INSTR;
        end else begin
            state <= state_next;
            if (pc_advance) begin
                pc_q <= next_pc;
            end
            if (capture) begin
                instr_buf <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ImemBusyF  = 1'b1;
        instr      = NOP_INSTR;
        pc_advance = 1'b0;
        capture    = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                ImemBusyF = !imem_ack;
                if (imem_ack) begin
                    // Same-cycle bypass keeps zero-wait memory at one instruction per cycle.
                    instr = imem_rdata;
                    if (StallF) begin
                        // Downstream is stalled: park the word, since memory will not repeat it.
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        pc_advance = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                ImemBusyF = 1'b0;
                instr     = instr_buf;
                if (!StallF) begin
                    pc_advance = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] instr;
    logic        ImemBusyF;

    logic        use_model;
    logic [31:0] rdata_val;
    int          n_cmp;
    int          n_err;

    if_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .instr      (instr),
        .ImemBusyF  (ImemBusyF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_rdata = use_model ? (imem_addr | 32'h0000_1000) : rdata_val;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        StallF    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        JumpD     = 1'b0;
        PCJumpD   = 32'h0;
        imem_ack  = 1'b0;
        use_model = 1'b1;
        rdata_val = 32'h0;
    endtask

    // Leaves the DUT in S_BOOT, one edge before the first request.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", imem_req); end
        n_cmp++; if (ImemBusyF !== 1'b1) begin n_err++; $display("FAIL rst_busy got %0b want 1", ImemBusyF); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 00000000", instr); end
        n_cmp++; if (PCF !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 00000000", PCF); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req got %0b want 0", imem_req); end
        n_cmp++; if (ImemBusyF !== 1'b1) begin n_err++; $display("FAIL boot_busy got %0b want 1", ImemBusyF); end
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4);
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL zw_req[%0d] got %0b want 1", i, imem_req); end
            n_cmp++; if (imem_addr !== pc) begin n_err++; $display("FAIL zw_addr[%0d] got %h want %h", i, imem_addr, pc); end
            n_cmp++; if (instr !== (pc | 32'h1000)) begin n_err++; $display("FAIL zw_instr[%0d] got %h want %h", i, instr, pc | 32'h1000); end
            n_cmp++; if (PCPlus4F !== pc + 32'd4) begin n_err++; $display("FAIL zw_pc4[%0d] got %h want %h", i, PCPlus4F, pc + 32'd4); end
            n_cmp++; if (ImemBusyF !== 1'b0) begin n_err++; $display("FAIL zw_busy[%0d] got %0b want 0", i, ImemBusyF); end
            step();
        end
    endtask

    // Entered with PCF = 0x10 and ack every third cycle; StallF mirrors busy.
    task automatic test_two_wait();
        logic [31:0] base;
        base = 32'h10;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                imem_ack = 1'b0;
                StallF   = 1'b1;
                @(negedge clk);
                n_cmp++; if (ImemBusyF !== 1'b1) begin n_err++; $display("FAIL tw_busy[%0d.%0d] got %0b want 1", k, w, ImemBusyF); end
                n_cmp++; if (imem_addr !== base) begin n_err++; $display("FAIL tw_addr[%0d.%0d] got %h want %h", k, w, imem_addr, base); end
                n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL tw_instr[%0d.%0d] got %h want 00000000", k, w, instr); end
                n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL tw_req[%0d.%0d] got %0b want 1", k, w, imem_req); end
                step();
            end
            imem_ack = 1'b1;
            StallF   = 1'b0;
            @(negedge clk);
            n_cmp++; if (ImemBusyF !== 1'b0) begin n_err++; $display("FAIL tw_ackbusy[%0d] got %0b want 0", k, ImemBusyF); end
            n_cmp++; if (instr !== (base | 32'h1000)) begin n_err++; $display("FAIL tw_ackinstr[%0d] got %h want %h", k, instr, base | 32'h1000); end
            step();
            base = base + 32'd4;
        end
        n_cmp++; if (PCF !== 32'h18) begin n_err++; $display("FAIL tw_endpc got %h want 00000018", PCF); end
    endtask

    task automatic test_stall_on_ack();
        do_reset();
        step();
        imem_ack = 1'b1;
        step();
        step();
        n_cmp++; if (PCF !== 32'h8) begin n_err++; $display("FAIL st_pc8 got %h want 00000008", PCF); end
        use_model = 1'b0;
        rdata_val = 32'hDEAD_BEEF;
        StallF    = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_bypass got %h want deadbeef", instr); end
        step();
        imem_ack  = 1'b0;
        rdata_val = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_hold_req[%0d] got %0b want 0", i, imem_req); end
            n_cmp++; if (ImemBusyF !== 1'b0) begin n_err++; $display("FAIL st_hold_busy[%0d] got %0b want 0", i, ImemBusyF); end
            n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_hold_instr[%0d] got %h want deadbeef", i, instr); end
            n_cmp++; if (PCF !== 32'h8) begin n_err++; $display("FAIL st_hold_pc[%0d] got %h want 00000008", i, PCF); end
            step();
        end
        StallF = 1'b0;
        step();
        n_cmp++; if (PCF !== 32'hC) begin n_err++; $display("FAIL st_resume_pc got %h want 0000000c", PCF); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL st_resume_req got %0b want 1", imem_req); end
        use_model = 1'b1;
    endtask

    // Entered at PCF = 0xC in S_FETCH.
    task automatic test_redirects();
        imem_ack = 1'b1;
        step();
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL rd_pc10 got %h want 00000010", imem_addr); end
        PCSrcD = 1'b1; PCBranchD = 32'h40;
        step();
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_branch got %h want 00000040", imem_addr); end
        imem_ack = 1'b0; PCBranchD = 32'h100;
        step();
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_noack got %h want 00000040", imem_addr); end
        imem_ack = 1'b1; PCBranchD = 32'h40; JumpD = 1'b1; PCJumpD = 32'h80;
        step();
        n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL rd_jump_prio got %h want 00000080", imem_addr); end
        JumpD = 1'b0; PCBranchD = 32'h43;
        step();
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_align got %h want 00000040", imem_addr); end
        PCSrcD = 1'b0;
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
        step();
        JumpD = 1'b0;
        @(negedge clk);
        n_cmp++; if (PCF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_pc got %h want fffffffc", PCF); end
        n_cmp++; if (PCPlus4F !== 32'h0) begin n_err++; $display("FAIL wr_pc4 got %h want 00000000", PCPlus4F); end
        step();
        n_cmp++; if (PCF !== 32'h0) begin n_err++; $display("FAIL wr_next got %h want 00000000", PCF); end
    endtask

    task automatic test_reset_mid_fetch();
        imem_ack = 1'b1; JumpD = 1'b1; PCJumpD = 32'h200;
        step();
        JumpD = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mf_req_before got %0b want 1", imem_req); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mf_req_drop got %0b want 0", imem_req); end
        n_cmp++; if (ImemBusyF !== 1'b1) begin n_err++; $display("FAIL mf_busy got %0b want 1", ImemBusyF); end
        n_cmp++; if (PCF !== 32'h0) begin n_err++; $display("FAIL mf_pc got %h want 00000000", PCF); end
        imem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mf_boot_req got %0b want 0", imem_req); end
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mf_fetch_req got %0b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL mf_fetch_addr got %h want 00000000", imem_addr); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zero_wait();
        test_two_wait();
        test_stall_on_ack();
        test_redirects();
        test_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID register.
- Holds the PC and selects the next PC from sequential, branch (PCSrcD) or jump redirects.
- Runs a request/acknowledge handshake with a variable-latency instruction memory.
- Drives instr and PCPlus4F into IF/ID. Raises ImemBusyF so the hazard unit can stall the front end while memory is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction presented while no valid fetch data exists (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- StallF  input  1  hazard-unit stall for fetch; externally includes ImemBusyF
- PCSrcD  input  1  taken branch resolved in decode
- PCBranchD  input  32  branch target
- JumpD  input  1  jump in decode
- PCJumpD  input  32  jump target
- imem_req  output  1  fetch request, level-held until acked
- imem_addr  output  32  fetch address; equals PCF
- imem_ack  input  1  read data valid this cycle; meaningful only while imem_req=1
- imem_rdata  input  32  instruction word
- PCF  output  32  current fetch PC
- PCPlus4F  output  32  PCF + 4, to IF/ID
- instr  output  32  fetched instruction, to IF/ID
- ImemBusyF  output  1  fetch outstanding; hazard unit must stall F and D

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=S_BOOT, instr buffer=NOP_INSTR.
  - imem_req=0, ImemBusyF=1, instr=NOP_INSTR.
  - Assertion mid-transaction drops imem_req combinationally; the pending ack is ignored.
- States:
  - S_BOOT: one cycle after reset release; no request; ImemBusyF=1; next state S_FETCH unconditionally.
  - S_FETCH: imem_req=1, imem_addr=PCF; ImemBusyF=!imem_ack.
    - ack=1 and StallF=0: PCF<=next_pc; stay in S_FETCH (back-to-back fetch, one instruction per cycle with zero-wait memory).
    - ack=1 and StallF=1: buffer<=imem_rdata; go to S_HOLD.
    - ack=0: hold PCF; redirects are ignored, because ImemBusyF forces StallF.
  - S_HOLD: imem_req=0, ImemBusyF=0, instr=buffer.
    - StallF=0: PCF<=next_pc; go to S_FETCH.
- instr mux:
  - S_FETCH with ack: imem_rdata (combinational bypass).
  - S_HOLD: buffer.
  - Otherwise: NOP_INSTR.
- next_pc priority: JumpD → PCJumpD; else PCSrcD → PCBranchD; else PCF+4.
  - Bits [1:0] of the selected target are forced to 0.
  - Redirect takes effect only on an edge where PCF advances, i.e. StallF=0 with valid data.
  - The wrong-path slot already presented is flushed by IF/ID CLR, not by this block.
- Arithmetic: PCPlus4F=PCF+32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- StallF=1 in S_FETCH without ack has no effect; the request stays up and the address stays stable.

Test Plan:
- Reset then zero-wait memory (ack tied 1, rdata=addr|0x1000):
  - Cycle after S_BOOT: imem_addr=0.
  - Consecutive cycles: 0,4,8,C.
  - instr=0x1000,0x1004,…
  - PCPlus4F tracks PCF+4.
- Two-wait memory (ack every third cycle):
  - ImemBusyF=1 for two cycles per fetch; PCF holds.
  - imem_addr stable; instr=NOP while waiting.
- Stall on ack cycle (StallF=1 when ack at PC=8, rdata=0xDEADBEEF):
  - Enters S_HOLD; imem_req=0; instr=0xDEADBEEF held.
  - After StallF drops: PCF=C, request reissued.
- Redirects (ack at PC=0x10):
  - PCSrcD=1, PCBranchD=0x40 → next imem_addr=0x40.
  - JumpD=1, PCJumpD=0x80 with PCSrcD=1 → 0x80.
  - Target 0x43 → 0x40.
- Wrap: PCF forced to 0xFFFFFFFC with ack → PCPlus4F=0, next PCF=0.
- Reset mid-fetch:
  - rst_n low during outstanding request → imem_req=0 immediately.
  - After release: S_BOOT, then fetch at RESET_PC.
